// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_e;

    localparam int unsigned DB_CNT_DEF     = 1_000_000;
    localparam int unsigned REP_DELAY_DEF  = 25_000_000;
    localparam int unsigned REP_PERIOD_DEF = 5_000_000;

    // Bits needed for a counter that runs 0 .. max_cnt-1 (never below one bit).
    function automatic int unsigned cnt_width(input int unsigned max_cnt);
        return (max_cnt < 32'd2) ? 32'd1 : 32'($clog2(max_cnt));
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single-key debouncer: two-flop synchronizer, four-state FSM and debounce counter.
// Optional auto-repeat on held keys when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CNT     = DB_CNT_DEF
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic push_n,
    output logic level_o,
    output logic press_o,
    output logic rel_o
);

    localparam int unsigned      CNT_W    = cnt_width(DB_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned      REP_W     = cnt_width((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_periodic_q, rep_periodic_d;
`endif

    // Next-state, counters and output pulses; sync2_q is the pressed flag.
    always_comb begin
        sync1_d  = ~push_n;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_cnt_d      = rep_cnt_q;
        rep_periodic_d = rep_periodic_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt_d      = '0;
                    rep_periodic_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    // First repeat after REP_DELAY, then every REP_PERIOD; paused in REL_WAIT.
                    if (rep_cnt_q == (rep_periodic_q ? REP_NEXT : REP_FIRST)) begin
                        press_d        = 1'b1;
                        rep_cnt_d      = '0;
                        rep_periodic_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end
            end
            REL_WAIT: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q      <= rep_cnt_d;
            rep_periodic_q <= rep_periodic_d;
`endif
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;

endmodule

// File: rtl/key_debounce.sv
// N_KEY independent push-button debouncers with press/release pulses.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat PRESS pulses on held keys.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned N_KEY      = 4,
    parameter int unsigned DB_CNT     = DB_CNT_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_KEY-1:0] PUSH,
    output logic [N_KEY-1:0] LEVEL,
    output logic [N_KEY-1:0] PRESS,
    output logic [N_KEY-1:0] RELEASE
);

    for (genvar i = 0; i < int'(N_KEY); i++) begin : g_key
        key_debounce_ch #(
            .DB_CNT     (DB_CNT)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
`endif
        ) u_ch (
            .clk     (CLK),
            .rst     (RST),
            .push_n  (PUSH[i]),
            .level_o (LEVEL[i]),
            .press_o (PRESS[i]),
            .rel_o   (RELEASE[i])
        );
    end

`ifndef KEY_AUTOREPEAT_EN
    // Repeat timing has no effect without auto-repeat.
    if (REP_DELAY == 0 || REP_PERIOD == 0) begin : g_rep_timing_inert
    end
`endif

endmodule
